// File: rtl/vm_pkg.sv
// ============================================================
// vm_pkg : shared constants and types for the vending front end
// Rev 1.0
// ============================================================
`default_nettype none

package vm_pkg;

  localparam int TOTAL_W = 10;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  localparam logic [1:0] OPT_TEA    = 2'd1;
  localparam logic [1:0] OPT_COFFEE = 2'd2;

  localparam logic [TOTAL_W-1:0] PRICE_TEA    = 10'd5;
  localparam logic [TOTAL_W-1:0] PRICE_COFFEE = 10'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  function automatic logic [TOTAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  coin_value = 10'd1;
      COIN_2:  coin_value = 10'd2;
      COIN_5:  coin_value = 10'd5;
      default: coin_value = 10'd10;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter5.sv
// ============================================================
// sat_counter5 : 5-bit up counter that sticks at 31, sync clear
// Rev 1.0
// ============================================================
`default_nettype none

module sat_counter5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [4:0] count,
  output logic       sat
);

  assign sat = (count == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 5'd0;
    end else if (clr) begin
      count <= 5'd0;
    end else if (inc && !sat) begin
      count <= count + 5'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coin_collector.sv
// ============================================================
// coin_collector : coin/selection intake, presents paid orders, refunds aborts
// Rev 1.0
// ============================================================
`default_nettype none

module coin_collector
  import vm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               sel_valid,
  input  logic [1:0]         sel_option,
  input  logic               cancel,
  output logic [4:0]         coin1,
  output logic [4:0]         coin2,
  output logic [4:0]         coin5,
  output logic [4:0]         coin10,
  output logic [1:0]         option,
  output logic               enable,
  output logic [TOTAL_W-1:0] total,
  output logic               coin_reject,
  output logic               sel_error,
  output logic               refund_valid,
  output logic [TOTAL_W-1:0] refund_amount
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t             state, state_next;
  logic [TW-1:0]      timer;
  logic [3:0][4:0]    cnt;
  logic [3:0]         sat, inc;
  logic               in_idle, in_collect, timeout_hit, abort, window;
  logic               coin_ok, sel_is_valid, sel_ok, sel_bad, price_met;
  logic [TOTAL_W-1:0] price;

  assign in_idle      = (state == IDLE);
  assign in_collect   = (state == COLLECT);
  assign timeout_hit  = in_collect && (timer == TW'(TIMEOUT_CYCLES - 1));
  // Cancel/timeout win over everything else arriving in the same cycle
  assign abort        = in_collect && (cancel || timeout_hit);
  assign window       = in_idle || (in_collect && !abort);
  assign coin_ok      = coin_valid && window && !sat[coin_type];
  assign sel_is_valid = (sel_option == OPT_TEA) || (sel_option == OPT_COFFEE);
  assign sel_ok       = sel_valid && window && sel_is_valid;
  assign sel_bad      = sel_valid && (in_idle || in_collect) && !sel_is_valid;
  assign inc          = coin_ok ? (4'b0001 << coin_type) : 4'b0000;
  assign price        = (option == OPT_TEA) ? PRICE_TEA : PRICE_COFFEE;
  assign price_met    = (option != 2'd0) && (total >= price);

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    sat_counter5 u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .clr   (state == CLEAR),
      .count (cnt[i]),
      .sat   (sat[i])
    );
  end

  assign coin1  = cnt[0];
  assign coin2  = cnt[1];
  assign coin5  = cnt[2];
  assign coin10 = cnt[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (coin_ok || sel_ok) state_next = COLLECT;
      COLLECT: begin
        if (abort)          state_next = CLEAR;
        else if (price_met) state_next = PRESENT;
      end
      PRESENT: state_next = CLEAR;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      option        <= 2'd0;
      total         <= '0;
      enable        <= 1'b0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
      timer         <= '0;
    end else begin
      if (state == CLEAR) begin
        option <= 2'd0;
        total  <= '0;
      end else begin
        if (sel_ok)  option <= sel_option;
        if (coin_ok) total  <= total + coin_value(coin_type);
      end
      enable       <= (state_next == PRESENT);
      coin_reject  <= coin_valid && !coin_ok;
      sel_error    <= sel_bad;
      refund_valid <= abort;
      if (abort) refund_amount <= total;
      // Idle timer only advances across quiet cycles spent in COLLECT
      if (!in_collect || (state_next != COLLECT) || coin_ok || sel_ok)
        timer <= '0;
      else
        timer <= timer + TW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_collector.sv
// ============================================================
// tb_coin_collector : directed checks of coin_collector
// Rev 1.0
// ============================================================
`default_nettype none

module tb_coin_collector;
  import vm_pkg::*;

  localparam int T = 30;

  logic       clk, rst_n;
  logic       coin_valid, sel_valid, cancel;
  logic [1:0] coin_type, sel_option;
  logic [4:0] coin1, coin2, coin5, coin10;
  logic [1:0] option;
  logic       enable, coin_reject, sel_error, refund_valid;
  logic [9:0] total, refund_amount;

  int checks = 0;
  int errors = 0;
  int n;

  coin_collector #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_option(sel_option), .cancel(cancel),
    .coin1(coin1), .coin2(coin2), .coin5(coin5), .coin10(coin10),
    .option(option), .enable(enable), .total(total),
    .coin_reject(coin_reject), .sel_error(sel_error),
    .refund_valid(refund_valid), .refund_amount(refund_amount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [1:0] o);
    sel_valid  = 1'b1;
    sel_option = o;
    tick();
    sel_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0;
    sel_valid = 1'b0; sel_option = 2'd0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_total", total, 0);
    chk("rst_coin1", coin1, 0);
    chk("rst_option", option, 0);
    chk("rst_enable", enable, 0);
    chk("rst_refund_valid", refund_valid, 0);
    chk("rst_refund_amount", refund_amount, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_sel_error", sel_error, 0);
    rst_n = 1'b1;
    tick();

    // 1: tea then Rs.5
    sel(OPT_TEA);
    chk("t1_option_latched", option, 1);
    coin(COIN_5);
    chk("t1_total_n1", total, 5);
    chk("t1_enable_n1", enable, 0);
    tick();
    chk("t1_enable_n2", enable, 1);
    chk("t1_coin5", coin5, 1);
    chk("t1_option", option, 1);
    chk("t1_total", total, 5);
    tick();
    chk("t1_enable_one_cycle", enable, 0);
    chk("t1_coin5_held_clear", coin5, 1);
    tick();
    chk("t1_coin5_cleared", coin5, 0);
    chk("t1_total_cleared", total, 0);
    chk("t1_option_cleared", option, 0);

    // 2: coffee, 2+2+5 short, then Rs.1
    sel(OPT_COFFEE);
    coin(COIN_2);
    coin(COIN_2);
    coin(COIN_5);
    chk("t2_total9", total, 9);
    tick();
    chk("t2_no_enable_at9", enable, 0);
    coin(COIN_1);
    chk("t2_total10", total, 10);
    tick();
    chk("t2_enable", enable, 1);
    chk("t2_coin1", coin1, 1);
    chk("t2_coin2", coin2, 2);
    chk("t2_coin5", coin5, 1);
    chk("t2_option", option, 2);
    tick();
    tick();
    chk("t2_total_cleared", total, 0);

    // 3: three Rs.10, no selection, cancel
    coin(COIN_10);
    coin(COIN_10);
    coin(COIN_10);
    tick();
    chk("t3_no_enable", enable, 0);
    chk("t3_coin10", coin10, 3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t3_refund_valid", refund_valid, 1);
    chk("t3_refund_amount", refund_amount, 30);
    chk("t3_enable", enable, 0);
    tick();
    chk("t3_refund_one_cycle", refund_valid, 0);
    chk("t3_total_cleared", total, 0);

    // 4: saturate coin1, then timeout
    for (int i = 0; i < 31; i++) coin(COIN_1);
    chk("t4_coin1_31", coin1, 31);
    chk("t4_no_reject_31", coin_reject, 0);
    coin(COIN_1);
    chk("t4_reject_32", coin_reject, 1);
    chk("t4_coin1_sat", coin1, 31);
    chk("t4_total31", total, 31);
    n = 0;
    while (!refund_valid && n < T + 10) begin
      tick();
      n++;
    end
    chk("t4_timeout_refund_valid", refund_valid, 1);
    chk("t4_timeout_amount", refund_amount, 31);
    chk("t4_timeout_latency", n, T - 1);
    tick();
    chk("t4_total_cleared", total, 0);

    // 5: invalid selection, then cancel racing a coin
    sel(2'd3);
    chk("t5_sel_error", sel_error, 1);
    chk("t5_option_kept", option, 0);
    tick();
    chk("t5_sel_error_one_cycle", sel_error, 0);
    sel(OPT_TEA);
    chk("t5_option_tea", option, 1);
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin_type = COIN_5;
    tick();
    cancel = 1'b0;
    coin_valid = 1'b0;
    chk("t5_coin_reject", coin_reject, 1);
    chk("t5_refund_valid", refund_valid, 1);
    chk("t5_refund_amount", refund_amount, 0);
    chk("t5_no_enable", enable, 0);
    tick();
    tick();
    chk("t5_no_enable_later", enable, 0);

    // 6: async reset mid-collect, then coin during PRESENT
    coin(COIN_5);
    coin(COIN_2);
    chk("t6_total7", total, 7);
    rst_n = 1'b0;
    #1;
    chk("t6_async_total", total, 0);
    chk("t6_async_coin5", coin5, 0);
    chk("t6_async_refund", refund_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_refund_after_rst", refund_valid, 0);
    sel(OPT_TEA);
    coin(COIN_10);
    chk("t6_total10", total, 10);
    tick();
    chk("t6_enable", enable, 1);
    coin(COIN_1);
    chk("t6_present_reject", coin_reject, 1);
    chk("t6_present_coin1", coin1, 0);
    chk("t6_present_coin10", coin10, 1);
    chk("t6_present_total", total, 10);
    tick();
    chk("t6_total_cleared", total, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/coin_collector.md
Name: coin_collector

Overview:
- Upstream stage of the vending machine.
- Accepts coins one at a time and the customer's drink selection, and keeps saturating per-denomination coin counts.
- Once payment covers the selected price, it presents coin1/coin2/coin5/coin10 and option to the vending machine with a one-cycle enable.
- Cancel and inactivity timeout return the collected money through a refund output. They do not go through the vending machine.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT before an automatic refund. Must be ≥ 2.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- coin_valid  input  1  one-cycle strobe: a coin is inserted.
- coin_type  input  2  denomination code: 00=Rs.1, 01=Rs.2, 10=Rs.5, 11=Rs.10.
- sel_valid  input  1  one-cycle strobe: a selection is made.
- sel_option  input  2  1=tea, 2=coffee; 0 and 3 are invalid.
- cancel  input  1  one-cycle strobe: customer aborts.
- coin1, coin2, coin5, coin10  output  5 each  coin counts presented downstream.
- option  output  2  latched selection presented downstream.
- enable  output  1  one-cycle "transaction ready" strobe to the vending machine.
- total  output  10  running Rs. value, = coin1 + 2·coin2 + 5·coin5 + 10·coin10. Maximum is 558.
- coin_reject  output  1  one-cycle pulse: the coin was not accepted and is returned.
- sel_error  output  1  one-cycle pulse: sel_option was invalid.
- refund_valid  output  1  one-cycle pulse: refund_amount is valid.
- refund_amount  output  10  value returned on cancel or timeout.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State goes to IDLE.
  - All counts, option and total are 0.
  - enable, coin_reject, sel_error and refund_valid are 0; refund_amount is 0.
  - A reset mid-transaction discards counts with no refund pulse.
- All outputs are registered. The strobe outputs are high for exactly one cycle.
- FSM states: IDLE, COLLECT, PRESENT, CLEAR.
- IDLE:
  - An accepted coin or a valid selection updates the counts/option and moves to COLLECT.
  - cancel is ignored.
- COLLECT, coins:
  - An accepted coin increments its counter by 1.
  - A counter already at 31 does not increment; coin_reject pulses the next cycle.
- COLLECT, selection:
  - A valid selection overwrites option; the latest selection wins.
  - An invalid selection pulses sel_error and leaves option unchanged.
- COLLECT, price check: price is 5 for option 1 and 10 for option 2. The check uses registered total and option.
  - Go to PRESENT when option ≠ 0 and total ≥ price.
  - Latency: a coin strobed in cycle N updates total after edge N; PRESENT is entered after edge N+1; enable is high in cycle N+2.
- COLLECT, cancel or timeout: on cancel, or when the timeout counter reaches TIMEOUT_CYCLES-1:
  - refund_valid pulses with refund_amount = total;
  - state goes to CLEAR.
- COLLECT, timeout counter: clears on any accepted coin, valid selection or state change, and otherwise increments.
- PRESENT:
  - enable = 1 for this single cycle.
  - Counts and option are held stable from entry through the following CLEAR cycle.
  - The next state is CLEAR unconditionally.
- CLEAR:
  - Counts, option and total are zeroed.
  - The next state is IDLE.
- Coins in PRESENT or CLEAR are rejected with coin_reject. sel_valid in PRESENT or CLEAR is ignored.
- Simultaneous events:
  - coin + selection in the same cycle: both are applied.
  - cancel + coin: cancel wins, the coin is rejected, and the refund excludes it.
  - Price satisfied while cancel arrives in COLLECT: cancel wins.
- Change and overpayment are computed downstream. This block never computes change.

Decomposition:
- Package vm_pkg holds:
  - coin code constants COIN_1/2/5/10;
  - OPT_TEA=2'd1, OPT_COFFEE=2'd2;
  - PRICE_TEA=5, PRICE_COFFEE=10;
  - the state enum;
  - TOTAL_W=10.
- One sub-module, sat_counter5: a 5-bit counter with inc and clr inputs and a sat flag, saturating at 31. It is instantiated four times.

Test Plan:
1. Reset, sel tea (1), then Rs.5 coin → enable high exactly 2 cycles after the coin, with coin5=1, option=1, total=5. All counts are 0 two cycles later.
2. sel coffee (2), then coins 2, 2, 5 → no enable (total=9). Then coin 1 → enable with coin1=1, coin2=2, coin5=1, option=2, total=10.
3. Three Rs.10 coins with no selection, then cancel → refund_valid with refund_amount=30, no enable, return to IDLE with total=0.
4. 32 Rs.1 coins → the 32nd gets coin_reject and coin1 stays 31 (total=31). Then idle for TIMEOUT_CYCLES → refund_amount=31.
5. sel_option=3 → sel_error pulse and option stays 0. Then sel 1, and cancel together with a Rs.5 coin → coin_reject, refund_amount=0, no enable.
6. Assert rst_n=0 asynchronously mid-COLLECT with total=7 → outputs clear immediately with no refund pulse. A coin during the PRESENT cycle → coin_reject and the presented counts are unchanged.
